// File: rtl/aes_inv_cipher_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM encoding, block type,
// inverse S-box and GF(2^8) helpers. Optional feature macro: AES_INV_CIPHER_ABORT_EN.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } fsm_e;

  // Block as [column][byte]; byte 3 of a column is row 0 (bits [31:24] of the bus word)
  typedef logic [3:0][3:0][7:0] block_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Bus between the inverse cipher core and its surroundings (ciphertext source,
// key-schedule lookup, plaintext sink). abort_in exists only with AES_INV_CIPHER_ABORT_EN.
interface aes_inv_cipher_if #(parameter int KEY_IDX_W = 4);

  logic                 start_in;
  logic [31:0]          ciphertext0_in;
  logic [31:0]          ciphertext1_in;
  logic [31:0]          ciphertext2_in;
  logic [31:0]          ciphertext3_in;
  logic [KEY_IDX_W-1:0] rkey_idx_out;
  logic [31:0]          rkey0_in;
  logic [31:0]          rkey1_in;
  logic [31:0]          rkey2_in;
  logic [31:0]          rkey3_in;
  logic [31:0]          plaintext0_out;
  logic [31:0]          plaintext1_out;
  logic [31:0]          plaintext2_out;
  logic [31:0]          plaintext3_out;
  logic                 valid_out;
  logic                 busy_out;
`ifdef AES_INV_CIPHER_ABORT_EN
  logic                 abort_in;

  modport master (
    output start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    output rkey0_in, rkey1_in, rkey2_in, rkey3_in, abort_in,
    input  rkey_idx_out, plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    input  valid_out, busy_out
  );

  modport slave (
    input  start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    input  rkey0_in, rkey1_in, rkey2_in, rkey3_in, abort_in,
    output rkey_idx_out, plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    output valid_out, busy_out
  );
`else
  modport master (
    output start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    output rkey0_in, rkey1_in, rkey2_in, rkey3_in,
    input  rkey_idx_out, plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    input  valid_out, busy_out
  );

  modport slave (
    input  start_in, ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in,
    input  rkey0_in, rkey1_in, rkey2_in, rkey3_in,
    output rkey_idx_out, plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out,
    output valid_out, busy_out
  );
`endif

endinterface

// File: rtl/aes_inv_cipher_round.sv
// One combinational inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey,
// then InvMixColumns when mix_en_i is set (the final round bypasses it).
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rkey_i,
  input  logic   mix_en_i,
  output block_t state_o
);

  block_t subbed;
  block_t keyed;
  block_t mixed;

  // Row r rotates right by r columns; every byte then goes through the inverse S-box
  always_comb begin
    subbed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        subbed[2'(c)][2'(3 - r)] = inv_sbox(state_i[2'(c - r)][2'(3 - r)]);
      end
    end
  end

  assign keyed = subbed ^ rkey_i;

  // Column-wise multiply by the inverse MixColumns matrix (0e 0b 0d 09 circulant)
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[2'(c)][3] = gf_mul(keyed[2'(c)][3], 8'h0e) ^ gf_mul(keyed[2'(c)][2], 8'h0b) ^
                        gf_mul(keyed[2'(c)][1], 8'h0d) ^ gf_mul(keyed[2'(c)][0], 8'h09);
      mixed[2'(c)][2] = gf_mul(keyed[2'(c)][3], 8'h09) ^ gf_mul(keyed[2'(c)][2], 8'h0e) ^
                        gf_mul(keyed[2'(c)][1], 8'h0b) ^ gf_mul(keyed[2'(c)][0], 8'h0d);
      mixed[2'(c)][1] = gf_mul(keyed[2'(c)][3], 8'h0d) ^ gf_mul(keyed[2'(c)][2], 8'h09) ^
                        gf_mul(keyed[2'(c)][1], 8'h0e) ^ gf_mul(keyed[2'(c)][0], 8'h0b);
      mixed[2'(c)][0] = gf_mul(keyed[2'(c)][3], 8'h0b) ^ gf_mul(keyed[2'(c)][2], 8'h0d) ^
                        gf_mul(keyed[2'(c)][1], 8'h09) ^ gf_mul(keyed[2'(c)][0], 8'h0e);
    end
  end

  assign state_o = mix_en_i ? mixed : keyed;

endmodule

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher core, one inverse round per clock, round keys fetched
// last-first through the rkey_idx_out lookup. Optional macro AES_INV_CIPHER_ABORT_EN
// adds abort_in to cancel a running decryption.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR,
  parameter int KEY_IDX_W = 4
) (
  input logic              CLK,
  input logic              RST,
  aes_inv_cipher_if.slave  bus
);

  fsm_e                 fsm_q, fsm_d;
  logic [KEY_IDX_W-1:0] roundCnt_q;
  block_t               aesState_q;
  block_t               pt_q;
  logic                 valid_q;

  block_t               ctIn;
  block_t               rkeyIn;
  block_t               roundOut;
  logic [KEY_IDX_W-1:0] rkeyIdx;
  logic                 busy;
  logic                 mixEn;
  logic                 abortHit;

  assign ctIn   = {bus.ciphertext3_in, bus.ciphertext2_in, bus.ciphertext1_in, bus.ciphertext0_in};
  assign rkeyIn = {bus.rkey3_in, bus.rkey2_in, bus.rkey1_in, bus.rkey0_in};

`ifdef AES_INV_CIPHER_ABORT_EN
  assign abortHit = bus.abort_in && (fsm_q != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  aes_inv_round u_round (
    .state_i  (aesState_q),
    .rkey_i   (rkeyIn),
    .mix_en_i (mixEn),
    .state_o  (roundOut)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) fsm_q <= IDLE;
    else      fsm_q <= fsm_d;
  end

  // Next state: abort wins over every transition out of RUN/LAST
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (bus.start_in) fsm_d = RUN;
      RUN: begin
        if (abortHit)                              fsm_d = IDLE;
        else if (roundCnt_q == KEY_IDX_W'(1))      fsm_d = LAST;
      end
      LAST:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Per-state outputs: key index to look up, round mode, busy flag
  always_comb begin
    rkeyIdx = KEY_IDX_W'(NR);
    mixEn   = 1'b0;
    busy    = 1'b0;
    unique case (fsm_q)
      IDLE: rkeyIdx = KEY_IDX_W'(NR);
      RUN: begin
        rkeyIdx = roundCnt_q;
        mixEn   = 1'b1;
        busy    = 1'b1;
      end
      LAST: begin
        rkeyIdx = '0;
        busy    = 1'b1;
      end
      default: rkeyIdx = KEY_IDX_W'(NR);
    endcase
  end

  // Datapath: initial key whitening on start, one round per RUN cycle, result capture in LAST
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      aesState_q <= '0;
      roundCnt_q <= '0;
      pt_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= (fsm_q == LAST) && !abortHit;
      unique case (fsm_q)
        IDLE: begin
          if (bus.start_in) begin
            aesState_q <= ctIn ^ rkeyIn;
            roundCnt_q <= KEY_IDX_W'(NR - 1);
          end
        end
        RUN: begin
          if (abortHit) begin
            roundCnt_q <= '0;
          end else begin
            aesState_q <= roundOut;
            roundCnt_q <= roundCnt_q - 1'b1;
          end
        end
        LAST: begin
          if (abortHit) roundCnt_q <= '0;
          else          pt_q       <= roundOut;
        end
        default: ;
      endcase
    end
  end

  assign bus.rkey_idx_out   = rkeyIdx;
  assign bus.busy_out       = busy;
  assign bus.valid_out      = valid_q;
  assign bus.plaintext0_out = pt_q[0];
  assign bus.plaintext1_out = pt_q[1];
  assign bus.plaintext2_out = pt_q[2];
  assign bus.plaintext3_out = pt_q[3];

endmodule
